// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: circular buffer, registered occupancy count,
// programmable almost-full/almost-empty, sticky error flags, fall-through output.
module fifo_param #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned AF_THRESH = 56,
  parameter int unsigned AE_THRESH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             datain,
  input  logic                         enw,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         enr,
  output logic                         valid,
  output logic [WIDTH-1:0]             dataout,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AeC    = CW'(AE_THRESH);
  localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic rd_acc;
  logic wr_acc;

  // All status flags come from the registered count, never from pointer compares.
  assign valid        = (count_q != '0);
  assign full         = (count_q == DepthC);
  assign almost_full  = (count_q >= AfC);
  assign almost_empty = (count_q <= AeC);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign rd_acc = enr & valid;
  // A write while full is still accepted if a pop frees a cell on the same edge.
  assign wr_acc = enw & (~full | rd_acc);

  assign dataout = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end

      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (enw & full & ~rd_acc) begin
        overflow_d = 1'b1;
      end
      // A read against an empty FIFO is not an error when a write fills it on the same edge.
      if (enr & ~valid & ~wr_acc) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr_q] <= datain;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed and randomized stimulus against a queue-based
// reference model, on a 64x8 instance and a non-power-of-two 5x8 instance.
module tb_fifo_param;

  logic clk = 1'b0;
  logic rst;

  logic       flush_a, enw_a, enr_a;
  logic [7:0] din_a, dout_a;
  logic       full_a, af_a, valid_a, ae_a, ovf_a, unf_a;
  logic [6:0] cnt_a;

  logic       flush_b, enw_b, enr_b;
  logic [7:0] din_b, dout_b;
  logic       full_b, af_b, valid_b, ae_b, ovf_b, unf_b;
  logic [2:0] cnt_b;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit ovf_ma, unf_ma, ovf_mb, unf_mb;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fifo_param #(.DEPTH(64), .WIDTH(8), .AF_THRESH(56), .AE_THRESH(8)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .datain(din_a), .enw(enw_a),
    .full(full_a), .almost_full(af_a), .enr(enr_a), .valid(valid_a),
    .dataout(dout_a), .almost_empty(ae_a), .count(cnt_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  fifo_param #(.DEPTH(5), .WIDTH(8), .AF_THRESH(4), .AE_THRESH(1)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .datain(din_b), .enw(enw_b),
    .full(full_b), .almost_full(af_b), .enr(enr_b), .valid(valid_b),
    .dataout(dout_b), .almost_empty(ae_b), .count(cnt_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag);
    int n = qa.size();
    chk({tag, ".count"}, 32'(cnt_a), n);
    chk({tag, ".full"}, 32'(full_a), 32'(n == 64));
    chk({tag, ".almost_full"}, 32'(af_a), 32'(n >= 56));
    chk({tag, ".almost_empty"}, 32'(ae_a), 32'(n <= 8));
    chk({tag, ".valid"}, 32'(valid_a), 32'(n != 0));
    chk({tag, ".overflow"}, 32'(ovf_a), 32'(ovf_ma));
    chk({tag, ".underflow"}, 32'(unf_a), 32'(unf_ma));
    if (n > 0) chk({tag, ".dataout"}, 32'(dout_a), 32'(qa[0]));
  endtask

  task automatic check_b(input string tag);
    int n = qb.size();
    chk({tag, ".count"}, 32'(cnt_b), n);
    chk({tag, ".full"}, 32'(full_b), 32'(n == 5));
    chk({tag, ".almost_full"}, 32'(af_b), 32'(n >= 4));
    chk({tag, ".almost_empty"}, 32'(ae_b), 32'(n <= 1));
    chk({tag, ".valid"}, 32'(valid_b), 32'(n != 0));
    chk({tag, ".overflow"}, 32'(ovf_b), 32'(ovf_mb));
    chk({tag, ".underflow"}, 32'(unf_b), 32'(unf_mb));
    if (n > 0) chk({tag, ".dataout"}, 32'(dout_b), 32'(qb[0]));
  endtask

  // Reference behaviour: a bounded queue with sticky error bits.
  task automatic model_a(input bit w, input bit r, input bit f, input logic [7:0] d);
    bit rd_ok, wr_ok;
    if (f) begin
      qa.delete(); ovf_ma = 0; unf_ma = 0;
    end else begin
      rd_ok = r && (qa.size() > 0);
      wr_ok = w && ((qa.size() < 64) || rd_ok);
      if (w && !wr_ok) ovf_ma = 1;
      if (r && (qa.size() == 0) && !wr_ok) unf_ma = 1;
      if (rd_ok) void'(qa.pop_front());
      if (wr_ok) qa.push_back(d);
    end
  endtask

  task automatic model_b(input bit w, input bit r, input bit f, input logic [7:0] d);
    bit rd_ok, wr_ok;
    if (f) begin
      qb.delete(); ovf_mb = 0; unf_mb = 0;
    end else begin
      rd_ok = r && (qb.size() > 0);
      wr_ok = w && ((qb.size() < 5) || rd_ok);
      if (w && !wr_ok) ovf_mb = 1;
      if (r && (qb.size() == 0) && !wr_ok) unf_mb = 1;
      if (rd_ok) void'(qb.pop_front());
      if (wr_ok) qb.push_back(d);
    end
  endtask

  task automatic step_a(input string tag, input bit w, input bit r, input bit f,
                        input logic [7:0] d);
    @(negedge clk);
    enw_a = w; enr_a = r; flush_a = f; din_a = d;
    enw_b = 0; enr_b = 0; flush_b = 0;
    @(posedge clk);
    model_a(w, r, f, d);
    #1;
    check_a(tag);
  endtask

  task automatic step_b(input string tag, input bit w, input bit r, input bit f,
                        input logic [7:0] d);
    @(negedge clk);
    enw_b = w; enr_b = r; flush_b = f; din_b = d;
    enw_a = 0; enr_a = 0; flush_a = 0;
    @(posedge clk);
    model_b(w, r, f, d);
    #1;
    check_b(tag);
  endtask

  initial begin
    rst = 1'b1;
    flush_a = 0; enw_a = 0; enr_a = 0; din_a = '0;
    flush_b = 0; enw_b = 0; enr_b = 0; din_b = '0;
    #12;
    check_a("reset_a");
    check_b("reset_b");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) step_a("fill", 1, 0, 0, 8'(i));
    for (int i = 0; i < 64; i++) step_a("drain", 0, 1, 0, 8'h00);
    step_a("extra_read", 0, 1, 0, 8'h00);

    step_a("flush_unf", 0, 0, 1, 8'h00);
    for (int i = 0; i < 64; i++) step_a("refill", 1, 0, 0, 8'(i));
    for (int i = 0; i < 10; i++) step_a("full_rw", 1, 1, 0, 8'hA0 + 8'(i));
    for (int i = 0; i < 64; i++) step_a("drain2", 0, 1, 0, 8'h00);

    for (int i = 0; i < 64; i++) step_a("fill3", 1, 0, 0, 8'(8'h40 + i));
    step_a("overflow", 1, 0, 0, 8'hEE);
    for (int i = 0; i < 44; i++) step_a("to20", 0, 1, 0, 8'h00);
    step_a("flush_wr", 1, 0, 1, 8'h77);

    step_a("empty_rw", 1, 1, 0, 8'h5A);
    step_a("after_rw", 0, 0, 0, 8'h00);

    for (int i = 0; i < 1500; i++) begin
      int pw = ((i / 200) % 2 == 0) ? 70 : 30;
      step_a("rand_a", $urandom_range(0, 99) < pw, $urandom_range(0, 99) >= pw,
             $urandom_range(0, 99) == 0, 8'($urandom));
    end

    step_b("b_flush", 0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) step_b("b_w3", 1, 0, 0, 8'h10 + 8'(i));
    for (int i = 0; i < 3; i++) step_b("b_r3", 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step_b("b_w4", 1, 0, 0, 8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) step_b("b_r4", 0, 1, 0, 8'h00);
    for (int i = 0; i < 500; i++) begin
      step_b("rand_b", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 63) == 0, 8'($urandom));
    end

    // Asynchronous reset landing between clock edges while writes are streaming.
    step_b("b_pre", 1, 0, 0, 8'h33);
    for (int i = 0; i < 5; i++) step_a("pre_rst", 1, 0, 0, 8'hC0 + 8'(i));
    #2;
    rst = 1'b1;
    enw_a = 0; enr_a = 0; flush_a = 0;
    enw_b = 0; enr_b = 0; flush_b = 0;
    #1;
    qa.delete(); ovf_ma = 0; unf_ma = 0;
    qb.delete(); ovf_mb = 0; unf_mb = 0;
    chk("async_rst.count", 32'(cnt_a), 0);
    chk("async_rst.valid", 32'(valid_a), 0);
    check_a("async_rst_a");
    check_b("async_rst_b");
    @(negedge clk);
    rst = 1'b0;
    step_a("post_rst", 0, 0, 0, 8'h00);
    step_a("post_rst_w", 1, 0, 0, 8'h99);
    step_a("post_rst_r", 0, 1, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
